// File: rtl/la_pkg.sv
// Shared constants for the logic-analyzer capture core: FSM state encoding and trigger-mode selects.
package la_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } la_state_e;

  // trig_edge_i / trig_and_i encodings
  localparam logic TRIG_EDGE = 1'b1;
  localparam logic COMB_AND  = 1'b1;

endpackage

// File: rtl/la_sdpram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module la_sdpram #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: pre/post-trigger circular capture into a sample buffer,
// configurable trigger evaluation, and trigger-relative readout.
module la_capture_core
  import la_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 1024,
  parameter  int unsigned TRIG_N = 4,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [TRIG_N-1:0]  trig_i,
  input  logic               arm_i,
  input  logic [TRIG_N-1:0]  trig_mask_i,
  input  logic [TRIG_N-1:0]  trig_pol_i,
  input  logic               trig_edge_i,
  input  logic               trig_and_i,
  input  logic [AW-1:0]      pretrig_i,
  input  logic [AW-1:0]      rd_addr_i,
  input  logic               rd_en_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic [STATE_W-1:0] state_o,
  output logic [AW-1:0]      trig_pos_o,
  output logic               done_o
);

  la_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [TRIG_N-1:0] trig_q, trig_prev_q;
  logic [TRIG_N-1:0] mask_q, pol_q;
  logic              edge_q, and_q;
  logic [AW-1:0]     pretrig_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     trig_pos_q, trig_pos_d;
  logic              done_q, rd_valid_q;
  logic              load_cfg_c, wr_en_c, hit_c, rd_re_c;
  logic [TRIG_N-1:0] src_hit_c;
  logic [AW-1:0]     rd_phys_c;

  // Input pipeline; trig_prev_q is the edge-detect history aligned with data_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q      <= '0;
      trig_q      <= '0;
      trig_prev_q <= '0;
    end else begin
      data_q      <= data_i;
      trig_q      <= trig_i;
      trig_prev_q <= trig_q;
    end
  end

  // Trigger evaluation on the sample currently being written.
  always_comb begin
    src_hit_c = ~(trig_q ^ pol_q);
    if (edge_q == TRIG_EDGE) begin
      src_hit_c = src_hit_c & (trig_q ^ trig_prev_q);
    end
    if (and_q == COMB_AND) begin
      hit_c = (|mask_q) && (&(src_hit_c | ~mask_q));
    end else begin
      hit_c = |(src_hit_c & mask_q);
    end
  end

  // Next-state logic; cnt_q counts samples still to be written in PRE and POST.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    trig_pos_d = trig_pos_q;
    load_cfg_c = 1'b0;
    wr_en_c    = 1'b0;
    if (arm_i) begin
      load_cfg_c = 1'b1;
      wr_ptr_d   = '0;
      cnt_d      = pretrig_i;
      state_d    = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
    end else begin
      case (state_q)
        ST_PRE: begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (hit_c) begin
            trig_pos_d = wr_ptr_q;
            cnt_d      = ~pretrig_q;
            state_d    = (pretrig_q == {AW{1'b1}}) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      trig_pos_q <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      pretrig_q  <= '0;
      mask_q     <= '0;
      pol_q      <= '0;
      edge_q     <= 1'b0;
      and_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      trig_pos_q <= trig_pos_d;
      done_q     <= (state_d == ST_DONE);
      rd_valid_q <= rd_re_c;
      if (load_cfg_c) begin
        pretrig_q <= pretrig_i;
        mask_q    <= trig_mask_i;
        pol_q     <= trig_pol_i;
        edge_q    <= trig_edge_i;
        and_q     <= trig_and_i;
      end
    end
  end

  // Logical index 0 is the oldest pre-trigger sample.
  assign rd_phys_c = trig_pos_q - pretrig_q + rd_addr_i;
  assign rd_re_c   = rd_en_i && (state_q == ST_DONE);

  la_sdpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_q),
    .re_i    (rd_re_c),
    .raddr_i (rd_phys_c),
    .rdata_o (rd_data_o)
  );

  assign state_o    = state_q;
  assign trig_pos_o = trig_pos_q;
  assign done_o     = done_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: directed capture scenarios plus random configurations,
// checked against a sample-history model of the capture rules.
module tb_la_capture_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TRIG_N = 4;
  localparam int unsigned AW     = 4;
  localparam int unsigned HIST   = 4096;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [DATA_W-1:0] data_i;
  logic [TRIG_N-1:0] trig_i;
  logic              arm_i;
  logic [TRIG_N-1:0] trig_mask_i, trig_pol_i;
  logic              trig_edge_i, trig_and_i;
  logic [AW-1:0]     pretrig_i, rd_addr_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic [2:0]        state_o;
  logic [AW-1:0]     trig_pos_o;
  logic              done_o;

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TRIG_N(TRIG_N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .trig_i(trig_i), .arm_i(arm_i),
    .trig_mask_i(trig_mask_i), .trig_pol_i(trig_pol_i), .trig_edge_i(trig_edge_i),
    .trig_and_i(trig_and_i), .pretrig_i(pretrig_i), .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .state_o(state_o),
    .trig_pos_o(trig_pos_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a = 1;
  bit m_active = 1'b0;
  int m_pre = 0;
  logic [3:0] m_mask, m_pol;
  logic m_edge, m_and;
  bit count_mode = 1'b0;
  logic [3:0] plan [256];
  logic [DATA_W-1:0] data_hist [HIST];
  logic [TRIG_N-1:0] trig_hist [HIST];
  logic [AW-1:0] exp_trig_pos = '0;
  logic [DATA_W-1:0] exp_rd_data = '0;

  // Record of exactly what the DUT sampled at every rising edge.
  always @(posedge clk_i) begin
    data_hist[cyc % HIST] = data_i;
    trig_hist[cyc % HIST] = trig_i;
    cyc = cyc + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 256; i++) plan[i] = 4'h0;
  endtask

  // Drive one sample from the plan (index relative to the last arm) and advance a cycle.
  task automatic tick();
    int r;
    r = cyc - a;
    data_i = count_mode ? DATA_W'(r) : DATA_W'($urandom);
    trig_i = (r >= 0 && r < 256) ? plan[r] : 4'h0;
    step();
  endtask

  task automatic tick_to(input int n);
    while (cyc - a < n) tick();
  endtask

  function automatic bit model_hit(input logic [3:0] cur, input logic [3:0] prev);
    int n_en, n_hit;
    n_en = 0;
    n_hit = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_mask[i]) begin
        n_en++;
        if (cur[i] == m_pol[i] && (!m_edge || cur[i] != prev[i])) n_hit++;
      end
    end
    if (n_en == 0) return 1'b0;
    return m_and ? (n_hit == n_en) : (n_hit > 0);
  endfunction

  // First sample index that triggers, considering samples already evaluated after k edges.
  function automatic int model_trig(input int k);
    for (int s = m_pre; s <= k - 1; s++)
      if (model_hit(trig_hist[(a + s) % HIST], trig_hist[(a + s - 1) % HIST])) return s;
    return -1;
  endfunction

  task automatic do_arm(input int pre, input logic [3:0] mask, input logic [3:0] pol,
                        input logic edg, input logic andm, input bit cnt);
    int t;
    if (m_active) begin
      t = model_trig(cyc - a - 1);
      if (t >= 0) exp_trig_pos = AW'(t);
    end
    a = cyc;
    m_active = 1'b1;
    m_pre = pre; m_mask = mask; m_pol = pol; m_edge = edg; m_and = andm;
    count_mode = cnt;
    arm_i = 1'b1;
    pretrig_i = AW'(pre); trig_mask_i = mask; trig_pol_i = pol;
    trig_edge_i = edg; trig_and_i = andm;
    tick();
    arm_i = 1'b0;
    pretrig_i = AW'($urandom); trig_mask_i = TRIG_N'($urandom); trig_pol_i = TRIG_N'($urandom);
    trig_edge_i = ~edg; trig_and_i = ~andm;
  endtask

  task automatic check_capture(input string tag);
    int k, t, post;
    logic [2:0] es;
    k = cyc - a - 1;
    t = model_trig(k);
    post = DEPTH - 1 - m_pre;
    if (k < m_pre) es = 3'd1;
    else if (t < 0) es = 3'd2;
    else if (k < t + post + 1) es = 3'd3;
    else es = 3'd4;
    if (t >= 0) exp_trig_pos = AW'(t);
    chk({tag, "_state"}, 32'(state_o), 32'(es));
    chk({tag, "_done"}, 32'(done_o), 32'(es == 3'd4));
    chk({tag, "_trigpos"}, 32'(trig_pos_o), 32'(exp_trig_pos));
    if (es == 3'd4) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_en_i = 1'b1;
        rd_addr_i = AW'(i);
        tick();
        exp_rd_data = data_hist[(a + t - m_pre + i) % HIST];
        chk({tag, "_rdvalid"}, 32'(rd_valid_o), 32'd1);
        chk({tag, "_rddata"}, 32'(rd_data_o), 32'(exp_rd_data));
      end
      rd_en_i = 1'b0;
      tick();
      chk({tag, "_rdidle"}, 32'(rd_valid_o), 32'd0);
    end else begin
      rd_en_i = 1'b1;
      rd_addr_i = AW'($urandom);
      tick();
      rd_en_i = 1'b0;
      chk({tag, "_rdblock_v"}, 32'(rd_valid_o), 32'd0);
      chk({tag, "_rdblock_d"}, 32'(rd_data_o), 32'(exp_rd_data));
    end
  endtask

  initial begin
    rst_i = 1'b1; data_i = '0; trig_i = '0; arm_i = 1'b0;
    trig_mask_i = '0; trig_pol_i = '0; trig_edge_i = 1'b0; trig_and_i = 1'b0;
    pretrig_i = '0; rd_addr_i = '0; rd_en_i = 1'b0;
    clear_plan();
    step(); step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_trigpos", 32'(trig_pos_o), 32'd0);
    chk("rst_rdvalid", 32'(rd_valid_o), 32'd0);
    chk("rst_rddata", 32'(rd_data_o), 32'd0);
    rst_i = 1'b0;
    step(); step();

    // Level OR trigger, data = sample index
    clear_plan();
    for (int i = 20; i < 23; i++) plan[i] = 4'b0001;
    do_arm(4, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    tick_to(40);
    check_capture("s1");
    chk("s1_pos_const", 32'(trig_pos_o), 32'd4);
    chk("s1_last_const", 32'(rd_data_o), 32'd31);

    // Falling edge on source 1
    clear_plan();
    for (int i = 25; i < 30; i++) plan[i] = 4'b0010;
    do_arm(4, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick_to(27);
    check_capture("s2_mid");
    tick_to(45);
    check_capture("s2");
    chk("s2_pos_const", 32'(trig_pos_o), 32'd14);

    // AND of two sources, overlap only at sample 15
    clear_plan();
    plan[10] = 4'b0001; plan[12] = 4'b0010; plan[15] = 4'b0011;
    do_arm(4, 4'b0011, 4'b0011, 1'b0, 1'b1, 1'b0);
    tick_to(14);
    check_capture("s3_mid");
    tick_to(35);
    check_capture("s3");
    chk("s3_pos_const", 32'(trig_pos_o), 32'd15);

    // Trigger during PRE is ignored
    clear_plan();
    plan[3] = 4'b0001; plan[4] = 4'b0001; plan[11] = 4'b0001;
    do_arm(8, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick_to(5);
    check_capture("s4_pre");
    tick_to(30);
    check_capture("s4");
    chk("s4_pos_const", 32'(trig_pos_o), 32'd11);

    // Maximum pretrigger: DONE right after the trigger sample
    clear_plan();
    plan[20] = 4'b0001;
    do_arm(15, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick_to(21);
    check_capture("s5_wait");
    check_capture("s5");
    chk("s5_pos_const", 32'(trig_pos_o), 32'd4);

    // Reset in POST, then a full capture
    clear_plan();
    plan[20] = 4'b0001;
    do_arm(4, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick_to(24);
    check_capture("s6_post");
    rst_i = 1'b1;
    #1;
    chk("s6_rst_state", 32'(state_o), 32'd0);
    chk("s6_rst_done", 32'(done_o), 32'd0);
    chk("s6_rst_trigpos", 32'(trig_pos_o), 32'd0);
    trig_i = '0;
    step();
    rst_i = 1'b0;
    m_active = 1'b0;
    exp_trig_pos = '0;
    exp_rd_data = '0;
    step(); step();
    clear_plan();
    plan[25] = 4'b0001;
    do_arm(6, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick_to(40);
    check_capture("s6_rearm");

    // Arm coincident with a hit wins
    clear_plan();
    plan[20] = 4'b0001;
    do_arm(4, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick_to(19);
    check_capture("s7_wait");
    tick_to(21);
    clear_plan();
    plan[10] = 4'b0001;
    do_arm(4, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    check_capture("s7_pre");
    chk("s7_pos_const", 32'(trig_pos_o), 32'd9);
    tick_to(30);
    check_capture("s7");

    // Random configurations
    for (int it = 0; it < 10; it++) begin
      clear_plan();
      for (int i = 0; i < 256; i++) plan[i] = 4'($urandom & $urandom & $urandom);
      do_arm(int'($urandom_range(1, 15)), 4'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'b0);
      tick_to(50);
      check_capture("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 Parameter DATA_W, default 8, captured sample width in bits (1..256).
REQ-002 Parameter DEPTH, default 1024, sample buffer depth; SHALL be a power of two, 16..65536.
REQ-003 Parameter TRIG_N, default 4, number of trigger inputs (1..16).
REQ-004 Derived constant AW = log2(DEPTH), address width.
REQ-005 clk_i  in  1  single capture clock; all logic rising-edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 data_i  in  DATA_W  probed signals, sampled every cycle.
REQ-008 trig_i  in  TRIG_N  trigger sources.
REQ-009 arm_i  in  1  single-cycle pulse; starts or restarts a capture.
REQ-010 trig_mask_i  in  TRIG_N  1 = source participates.
REQ-011 trig_pol_i  in  TRIG_N  1 = high/rising, 0 = low/falling.
REQ-012 trig_edge_i  in  1  1 = edge mode, 0 = level mode.
REQ-013 trig_and_i  in  1  1 = AND of enabled sources, 0 = OR.
REQ-014 pretrig_i  in  AW  samples kept before the trigger sample.
REQ-015 rd_addr_i  in  AW  logical readout index, 0 = oldest sample.
REQ-016 rd_en_i  in  1  readout request.
REQ-017 rd_data_o  out  DATA_W  readout sample.
REQ-018 rd_valid_o  out  1  rd_data_o valid.
REQ-019 state_o  out  3  current state encoding.
REQ-020 trig_pos_o  out  AW  physical address of the trigger sample.
REQ-021 done_o  out  1  high while in DONE.

Function
REQ-022 data_i and trig_i SHALL be registered once before use; a sample at cycle n is written to memory at cycle n+2.
REQ-023 States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4; pretrig_i, mask, polarity and mode inputs SHALL be latched on arm_i.
REQ-024 IDLE -> PRE on arm_i; pointer and counters cleared.
REQ-025 PRE: write each sample at wr_ptr, wr_ptr+1 mod DEPTH; -> WAIT once pretrig samples are written (immediately if pretrig = 0).
REQ-026 WAIT: keep writing circularly (wrap DEPTH-1 -> 0); triggers SHALL be ignored in PRE and evaluated only in WAIT.
REQ-027 Per-source hit: level mode = (trig == pol); edge mode = registered previous value != current and current == pol.
REQ-028 Combined hit = AND or OR over enabled sources; an all-zero mask SHALL never trigger in either mode.
REQ-029 On hit: the hit sample is written, trig_pos_o <= its address, -> POST; post count = DEPTH-1-pretrig.
REQ-030 POST: write the remaining post samples, then -> DONE; with pretrig = DEPTH-1, go DONE directly after the trigger sample.
REQ-031 DONE: no writes, done_o = 1; remain until arm_i.
REQ-032 Readout: physical address = (trig_pos - pretrig + rd_addr_i) mod DEPTH; rd_data_o and rd_valid_o SHALL follow rd_en_i by exactly 1 cycle.
REQ-033 rd_en_i outside DONE SHALL yield rd_valid_o = 0 and leave rd_data_o unchanged.
REQ-034 arm_i in any non-IDLE state SHALL restart at PRE, discarding the capture in progress; arm_i has priority over a simultaneous hit.

Reset
REQ-035 rst_i SHALL force state IDLE, wr_ptr 0, counters 0, trig_pos_o 0, rd_valid_o 0, done_o 0, rd_data_o 0, and the edge-history register 0.
REQ-036 Memory contents SHALL NOT be reset; reset mid-capture SHALL abort to IDLE with no further writes.

Structure
REQ-037 State encoding and trigger-mode constants SHALL reside in shared package la_pkg.
REQ-038 Sample storage SHALL be one sub-module la_sdpram (simple dual-port, 1-cycle registered read, inferable as BSRAM); trigger logic and FSM stay in la_capture_core.

Verification
REQ-039 DEPTH=16, pretrig=4, OR, level, mask=0001, pol=1; data = cycle count; trig_i[0] high at sample 20 -> DONE; logical 0..15 read 16..31; trig_pos_o = 20 mod 16 = 4.
REQ-040 Edge mode, pol=0 on source 1; source held low from arm -> no trigger; a 1->0 transition at sample 30 -> trigger sample = 30.
REQ-041 AND mode, mask=0011; sources high at samples 10 and 12 with no overlap -> no trigger; overlap at sample 15 -> trigger at 15.
REQ-042 Trigger asserted during PRE (pretrig=8, hit at sample 3) -> ignored; trigger only on the first hit after PRE completes.
REQ-043 pretrig=15, DEPTH=16 -> DONE the cycle after the trigger sample write; logical index 15 = trigger sample.
REQ-044 rst_i asserted in POST -> state_o=0, done_o=0 at once; re-arm -> full capture correct; arm_i coincident with hit -> PRE, no trigger recorded.
